// File: rtl/sync_timing_meas.sv
// sync_timing_meas: measures line/frame timing of polarity-normalized
// (active-low) HSYNC/VSYNC, produces pixel/line coordinates, start strobes
// and a LOCKED flag once the timing has repeated for LOCK_FRAMES frames.
//
// Optional build macro: SYNC_MEAS_GLITCH_FILTER_EN
//   defined   -> 3-sample majority filter on each sync input (+2 cycles latency)
//   undefined -> single input register, no filtering
//
// Ports:
//   PCLK        pixel clock, rising edge
//   RESET_N     asynchronous active-low reset
//   HS_N, VS_N  normalized active-low sync pulses
//   X, Y        pixel count in line, line count in frame
//   LINE_START  one-cycle strobe per HS_N falling edge
//   FRAME_START one-cycle strobe per VS_N falling edge
//   H_TOTAL     cycles between the last two line starts
//   H_SYNC      width of the last HS_N low pulse
//   V_TOTAL     line starts in the last complete frame
//   LOCKED      timing stable for LOCK_FRAMES frames
module sync_timing_meas #(
    parameter int unsigned HW          = 12,
    parameter int unsigned VW          = 11,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic          PCLK,
    input  logic          RESET_N,
    input  logic          HS_N,
    input  logic          VS_N,
    output logic [HW-1:0] X,
    output logic [VW-1:0] Y,
    output logic          LINE_START,
    output logic          FRAME_START,
    output logic [HW-1:0] H_TOTAL,
    output logic [HW-1:0] H_SYNC,
    output logic [VW-1:0] V_TOTAL,
    output logic          LOCKED
);

    localparam int unsigned MW = 4;
    localparam logic [HW-1:0] H_MAX  = {HW{1'b1}};
    localparam logic [VW-1:0] V_MAX  = {VW{1'b1}};
    localparam logic [MW-1:0] M_MAX  = {MW{1'b1}};
    localparam logic [MW-1:0] M_LOCK = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    // ------------------------------------------------------------------
    // Input stage: s_* is the sampled sync, d_* its one-cycle delay
    // ------------------------------------------------------------------
    logic s_hs_q, s_hs_d, s_vs_q, s_vs_d;
    logic d_hs_q, d_hs_d, d_vs_q, d_vs_d;

`ifdef SYNC_MEAS_GLITCH_FILTER_EN
    logic [2:0] hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;

    // 3-stage shift registers; s_* is the majority of the three samples
    always_comb begin
        hs_sr_d = {hs_sr_q[1:0], HS_N};
        vs_sr_d = {vs_sr_q[1:0], VS_N};
        s_hs_d  = (hs_sr_q[0] & hs_sr_q[1]) | (hs_sr_q[0] & hs_sr_q[2]) |
                  (hs_sr_q[1] & hs_sr_q[2]);
        s_vs_d  = (vs_sr_q[0] & vs_sr_q[1]) | (vs_sr_q[0] & vs_sr_q[2]) |
                  (vs_sr_q[1] & vs_sr_q[2]);
    end

    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_sr_q <= 3'b111;
            vs_sr_q <= 3'b111;
        end else begin
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
        end
    end
`else
    always_comb begin
        s_hs_d = HS_N;
        s_vs_d = VS_N;
    end
`endif

    // Edge detection, registered so counters act one cycle after detection
    logic line_edge_q, line_edge_d, frame_edge_q, frame_edge_d;
    logic hs_rise_q, hs_rise_d, hs_low_q, hs_low_d;

    always_comb begin
        d_hs_d       = s_hs_q;
        d_vs_d       = s_vs_q;
        line_edge_d  = d_hs_q & ~s_hs_q;
        frame_edge_d = d_vs_q & ~s_vs_q;
        hs_rise_d    = ~d_hs_q & s_hs_q;
        hs_low_d     = ~d_hs_q;
    end

    // Sync samples reset to the idle (high) level so release creates no edge
    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_hs_q       <= 1'b1;
            s_vs_q       <= 1'b1;
            d_hs_q       <= 1'b1;
            d_vs_q       <= 1'b1;
            line_edge_q  <= 1'b0;
            frame_edge_q <= 1'b0;
            hs_rise_q    <= 1'b0;
            hs_low_q     <= 1'b0;
        end else begin
            s_hs_q       <= s_hs_d;
            s_vs_q       <= s_vs_d;
            d_hs_q       <= d_hs_d;
            d_vs_q       <= d_vs_d;
            line_edge_q  <= line_edge_d;
            frame_edge_q <= frame_edge_d;
            hs_rise_q    <= hs_rise_d;
            hs_low_q     <= hs_low_d;
        end
    end

    // ------------------------------------------------------------------
    // Measurement counters and lock FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d, scnt_q, scnt_d;
    logic [HW-1:0] h_total_q, h_total_d, h_sync_q, h_sync_d, ref_h_q, ref_h_d;
    logic [VW-1:0] lcnt_q, lcnt_d, v_total_q, v_total_d, ref_v_q, ref_v_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          h_valid_q, h_valid_d, hmis_q, hmis_d, sat_q, sat_d;
    logic          locked_q, locked_d;

    logic [HW-1:0] h_period, scnt_inc;
    logic [VW-1:0] lcnt_inc, v_new;
    logic [MW-1:0] mcnt_inc;
    logic          h_sat, hmis_eff, sat_eff, match;

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        scnt_d        = scnt_q;
        h_total_d     = h_total_q;
        h_sync_d      = h_sync_q;
        ref_h_d       = ref_h_q;
        lcnt_d        = lcnt_q;
        v_total_d     = v_total_q;
        ref_v_d       = ref_v_q;
        mcnt_d        = mcnt_q;
        h_valid_d     = h_valid_q;
        hmis_d        = hmis_q;
        sat_d         = sat_q;
        line_start_d  = line_edge_q;
        frame_start_d = frame_edge_q;

        // Saturating increments; a saturated line period reports H_MAX
        h_period = (hcnt_q == H_MAX) ? H_MAX : hcnt_q + HW'(1);
        scnt_inc = (scnt_q == H_MAX) ? H_MAX : scnt_q + HW'(1);
        lcnt_inc = (lcnt_q == V_MAX) ? V_MAX : lcnt_q + VW'(1);
        mcnt_inc = (mcnt_q == M_MAX) ? M_MAX : mcnt_q + MW'(1);

        h_sat    = ~line_edge_q & (hcnt_q == H_MAX);
        // A line edge coincident with a frame edge belongs to the ending frame
        v_new    = line_edge_q ? lcnt_inc : lcnt_q;
        hmis_eff = hmis_q | (line_edge_q & h_valid_q & (h_period != h_total_q));
        sat_eff  = sat_q | h_sat;

        // Horizontal counter and line period
        if (line_edge_q) begin
            hcnt_d    = '0;
            h_total_d = h_period;
            h_valid_d = 1'b1;
        end else if (!h_sat) begin
            hcnt_d = hcnt_q + HW'(1);
        end
        if (h_sat) begin
            h_valid_d = 1'b0;
        end

        // Sync pulse width
        if (hs_rise_q) begin
            h_sync_d = scnt_inc;
            scnt_d   = '0;
        end else if (hs_low_q) begin
            scnt_d = scnt_inc;
        end

        // Line counter, frame totals and per-frame flags
        lcnt_d = v_new;
        hmis_d = hmis_eff;
        sat_d  = sat_eff;
        if (frame_edge_q) begin
            v_total_d = v_new;
            lcnt_d    = '0;
            hmis_d    = 1'b0;
            sat_d     = 1'b0;
        end

        match = (v_new == ref_v_q) && (h_total_d == ref_h_q) && !hmis_eff && !sat_eff;

        // Lock FSM; saturation overrides everything
        if (h_sat) begin
            state_d = ST_IDLE;
        end else if (frame_edge_q) begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    ref_h_d = h_total_d;
                    ref_v_d = v_new;
                    mcnt_d  = '0;
                    state_d = ST_MEASURE;
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (match) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc >= M_LOCK) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_h_d = h_total_d;
                        ref_v_d = v_new;
                        mcnt_d  = '0;
                        state_d = ST_MEASURE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            hcnt_q        <= '0;
            scnt_q        <= '0;
            h_total_q     <= '0;
            h_sync_q      <= '0;
            ref_h_q       <= '0;
            lcnt_q        <= '0;
            v_total_q     <= '0;
            ref_v_q       <= '0;
            mcnt_q        <= '0;
            h_valid_q     <= 1'b0;
            hmis_q        <= 1'b0;
            sat_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            scnt_q        <= scnt_d;
            h_total_q     <= h_total_d;
            h_sync_q      <= h_sync_d;
            ref_h_q       <= ref_h_d;
            lcnt_q        <= lcnt_d;
            v_total_q     <= v_total_d;
            ref_v_q       <= ref_v_d;
            mcnt_q        <= mcnt_d;
            h_valid_q     <= h_valid_d;
            hmis_q        <= hmis_d;
            sat_q         <= sat_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
        end
    end

    assign X           = hcnt_q;
    assign Y           = lcnt_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign H_TOTAL     = h_total_q;
    assign H_SYNC      = h_sync_q;
    assign V_TOTAL     = v_total_q;
    assign LOCKED      = locked_q;

endmodule

// File: tb/tb_sync_timing_meas.sv
// Bench for sync_timing_meas: drives a scaled-down video stream (100-cycle
// lines, 12-cycle HS pulse, 15 lines/frame, VS low for 2 lines starting with
// line 0), pushes the expected totals/LOCKED per FRAME_START to a queue and
// compares them when the strobe appears. Also covers async reset, line-period
// faults, a 1-cycle HS glitch and HCNT saturation.
`timescale 1ns/1ps
module tb_sync_timing_meas;

    localparam int unsigned HW = 12;
    localparam int unsigned VW = 11;
    localparam int unsigned LOCK_FRAMES = 2;
    localparam int LINE_LEN    = 100;
    localparam int SYNC_LEN    = 12;
    localparam int FRAME_LINES = 15;
    localparam int VS_LINES    = 2;
    localparam int MID         = 50;
    localparam int NFRAMES     = 20;

`ifdef SYNC_MEAS_GLITCH_FILTER_EN
    localparam int G_V = 15;
    localparam int G_L = 1;
`else
    localparam int G_V = 16;
    localparam int G_L = 0;
`endif

    logic          pclk = 1'b0;
    logic          reset_n;
    logic          hs_n;
    logic          vs_n;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [HW-1:0] h_total;
    logic [HW-1:0] h_sync;
    logic [VW-1:0] v_total;
    logic          locked;

    sync_timing_meas #(
        .HW(HW),
        .VW(VW),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .PCLK(pclk),
        .RESET_N(reset_n),
        .HS_N(hs_n),
        .VS_N(vs_n),
        .X(x),
        .Y(y),
        .LINE_START(line_start),
        .FRAME_START(frame_start),
        .H_TOTAL(h_total),
        .H_SYNC(h_sync),
        .V_TOTAL(v_total),
        .LOCKED(locked)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int v_total;
        int h_total;
        int h_sync;
        int locked;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    longint last_ls_cyc = 0;
    bit     rst_release = 1'b0;

    // Per-frame table: fault injection and expected values at that frame's FRAME_START
    int tbl_short [NFRAMES] = '{-1, -1, -1, -1,  7, -1, -1, 14, -1, -1,
                                -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    int tbl_glitch[NFRAMES] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                                -1,  6, -1, -1, -1, -1, -1, -1, -1, -1};
    int tbl_rst   [NFRAMES] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                                -1, -1, -1, -1, -1,  4, -1, -1, -1, -1};
    int tbl_v     [NFRAMES] = '{11, 15, 15, 15, 15, 15, 15, 15, 15, 15,
                                15, 15, G_V, 15, 15, 15, 11, 15, 15, 15};
    int tbl_h     [NFRAMES] = '{100, 100, 100, 100, 100, 100, 100, 100, 99, 100,
                                100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    int tbl_l     [NFRAMES] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0,
                                0, 1, G_L, G_L, G_L, 1, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_x"},       32'(x), 32'd0);
        check({pfx, "_y"},       32'(y), 32'd0);
        check({pfx, "_ls"},      32'(line_start), 32'd0);
        check({pfx, "_fs"},      32'(frame_start), 32'd0);
        check({pfx, "_h_total"}, 32'(h_total), 32'd0);
        check({pfx, "_h_sync"},  32'(h_sync), 32'd0);
        check({pfx, "_v_total"}, 32'(v_total), 32'd0);
        check({pfx, "_locked"},  32'(locked), 32'd0);
    endtask

    // One line: HS low for SYNC_LEN cycles, optional glitch / reset pulse at a cycle
    task automatic drive_line(input int len, input bit vs_low, input int glitch_cyc, input int rst_cyc);
        for (int c = 0; c < len; c++) begin
            @(negedge pclk);
            hs_n = (c < SYNC_LEN || c == glitch_cyc) ? 1'b0 : 1'b1;
            vs_n = vs_low ? 1'b0 : 1'b1;
            if (rst_release) begin
                #1 reset_n = 1'b1;
                rst_release = 1'b0;
            end
            if (c == rst_cyc) begin
                #1 reset_n = 1'b0;
                #1 check_outputs_zero("async_rst");
                rst_release = 1'b1;
            end
        end
    endtask

    task automatic drive_frame(input int first_line, input int short_line,
                               input int glitch_line, input int rst_line);
        for (int l = first_line; l < FRAME_LINES; l++) begin
            drive_line((l == short_line) ? LINE_LEN - 1 : LINE_LEN,
                       (l < VS_LINES),
                       (l == glitch_line) ? MID : -1,
                       (l == rst_line) ? MID : -1);
        end
    endtask

    initial begin
        forever begin
            @(posedge pclk);
            cyc <= cyc + 1;
        end
    end

    // Output monitor: scoreboard pop on each FRAME_START, strobe width checks
    initial begin
        bit   prev_fs = 1'b0;
        exp_t e;
        forever begin
            @(negedge pclk);
            if (prev_fs) begin
                check("fs_width", 32'(frame_start), 32'd0);
                check("ls_width_at_fs", 32'(line_start), 32'd0);
            end
            if (line_start) last_ls_cyc = cyc;
            if (frame_start) begin
                if (sb_q.size() == 0) begin
                    check("fs_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("v_total", 32'(v_total), 32'(e.v_total));
                    check("h_total", 32'(h_total), 32'(e.h_total));
                    check("h_sync",  32'(h_sync),  32'(e.h_sync));
                    check("locked",  32'(locked),  32'(e.locked));
                end
                check("fs_ls_coincide", 32'(line_start), 32'd1);
                check("fs_x", 32'(x), 32'd0);
                check("fs_y", 32'(y), 32'd0);
            end
            prev_fs = frame_start;
        end
    end

    initial begin
        exp_t e;
        int   waited;
        reset_n = 1'b0;
        hs_n    = 1'b1;
        vs_n    = 1'b1;
        repeat (4) @(negedge pclk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Start mid-frame, then run the frame table
        drive_frame(5, -1, -1, -1);
        for (int f = 0; f < NFRAMES; f++) begin
            e.v_total = tbl_v[f];
            e.h_total = tbl_h[f];
            e.h_sync  = SYNC_LEN;
            e.locked  = tbl_l[f];
            sb_q.push_back(e);
            drive_frame(0, tbl_short[f], tbl_glitch[f], tbl_rst[f]);
        end

        // Stop HS while locked: LOCKED must drop 4096 cycles after the last line start
        check("pre_sat_locked", 32'(locked), 32'd1);
        waited = 0;
        while (locked !== 1'b0 && waited < 6000) begin
            @(negedge pclk);
            waited++;
        end
        if (locked !== 1'b0) begin
            check("sat_timeout", 32'(locked), 32'd0);
        end else begin
            check("sat_latency", 32'(cyc - last_ls_cyc), 32'd4096);
        end
        check("sat_x", 32'(x), 32'd4095);
        repeat (20) @(negedge pclk);
        check("sat_x_hold", 32'(x), 32'd4095);
        check("sat_locked_hold", 32'(locked), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
